fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory request; accepted in the cycle it is high.
REQ-005 imem_addr  out  32  byte address of the request; valid while imem_req=1.
REQ-006 imem_rvalid  in  1  response strobe, at least 1 cycle after its request.
REQ-007 imem_rdata  in  32  instruction word; valid while imem_rvalid=1.
REQ-008 stall  in  1  decode/control stage cannot accept; hold IF/ID output.
REQ-009 branch_taken  in  1  single-cycle redirect from execute.
REQ-010 branch_target  in  32  redirect address; sampled when branch_taken=1.
REQ-011 if_valid  out  1  IF/ID register holds a live instruction.
REQ-012 if_instr  out  32  registered instruction word.
REQ-013 if_pc  out  32  address from which if_instr was fetched.
REQ-014 if_opcode  out  5  if_instr[31:27]; drives the control unit's opcode input directly.

Function
REQ-015 FSM states: FETCH (nothing outstanding), WAIT (one request outstanding), DISCARD (one outstanding request whose response is dropped).
REQ-016 At most one request is outstanding at any time.
REQ-017 issue_ok = !skid_valid && !(if_valid && stall); imem_req = issue_ok && !branch_taken && (state==FETCH || (state==WAIT && imem_rvalid)).
REQ-018 On issue: imem_addr = pc; pc <= pc+4, wrapping modulo 2^32; next state WAIT.
REQ-019 WAIT with imem_rvalid and no issue -> FETCH; WAIT without imem_rvalid -> WAIT.
REQ-020 Returned word with its pc is loaded into IF/ID when IF/ID is free (!if_valid || !stall); otherwise it goes into a one-entry skid buffer.
REQ-021 When IF/ID is free, the load priority is skid buffer, then the current response; if neither exists, if_valid <= 0.
REQ-022 Program order is preserved; no instruction is duplicated or lost without a redirect.
REQ-023 While if_valid=1 and stall=1, if_instr, if_pc and if_valid hold their values.
REQ-024 branch_taken has priority over every other event: pc <= {branch_target[31:2],2'b00}; if_valid <= 0; skid cleared; no issue that cycle.
REQ-025 branch_taken in WAIT without imem_rvalid -> DISCARD; in WAIT with imem_rvalid -> response dropped, go to FETCH.
REQ-026 DISCARD: imem_req=0; on imem_rvalid, drop the data and go to FETCH; a further branch_taken updates pc and stays in DISCARD.
REQ-027 Latency with 1-cycle memory: request in cycle N, if_valid=1 in N+2; sustained throughput one instruction per cycle when stall=0.

Reset
REQ-028 While rst_n=0 at a clock edge: pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, skid_valid=0.
REQ-029 imem_req is forced to 0 in any cycle where rst_n=0.
REQ-030 A response arriving within 1 cycle after reset release that belongs to a pre-reset request is discarded; reset mid-WAIT enters DISCARD state rather than FETCH, then proceeds per REQ-026.

Structure
REQ-031 Package cpu_pkg holds XLEN=32, OPCODE_W=5, OPCODE_MSB=31, the RESET_PC default and the fetch_state_t enum {FETCH, WAIT, DISCARD}.
REQ-032 The one-entry skid buffer is a sub-module, fetch_skid_buf (data+pc+valid, load/unload ports, sync clear).

Verification
REQ-033 Reset then 1-cycle memory returning 32'h0800_0000 at 0x0: imem_addr 0x0,0x4,0x8 on consecutive cycles; if_opcode=5'b00001 at cycle 2.
REQ-034 stall high 3 cycles while the word at 0x4 is in flight: no request issues; if_instr holds; the word at 0x4 is emitted next after stall drops, with no gap or duplicate.
REQ-035 branch_taken, branch_target=0x103, while WAIT: next issued imem_addr=0x100; the stale response is dropped; if_valid=0 for at least 1 cycle.
REQ-036 branch_taken coincident with imem_rvalid and stall=1: if_valid=0, skid empty, next request to the target.
REQ-037 pc=0xFFFF_FFFC fetch: next imem_addr=0x0000_0000.
REQ-038 rst_n low for 1 cycle while a request is outstanding: imem_req=0 that cycle; next issued imem_addr=RESET_PC; the late response is never emitted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, reset address and fetch FSM encoding for the CPU front end.
package cpu_pkg;
  localparam int XLEN       = 32;
  localparam int OPCODE_W   = 5;
  localparam int OPCODE_MSB = 31;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an instruction word that returns while IF/ID is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            unload,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // load wins over unload so a same-cycle refill keeps the slot occupied
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
    end else if (load && !clear) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, IF/ID register, skid slot, branch redirect.
// state   | meaning
// FETCH   | nothing outstanding, may issue
// WAIT    | one request outstanding, response will be used
// DISCARD | one request outstanding, response will be dropped
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_target,
  output logic                if_valid,
  output logic [XLEN-1:0]     if_instr,
  output logic [XLEN-1:0]     if_pc,
  output logic [OPCODE_W-1:0] if_opcode
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, req_pc;
  logic            ifid_free, issue_ok, resp;
  logic            skid_valid, skid_load, skid_unload;
  logic [XLEN-1:0] skid_instr, skid_pc;

  always_comb begin
    ifid_free   = !if_valid || !stall;
    issue_ok    = !skid_valid && !(if_valid && stall);
    imem_req    = rst_n && issue_ok && !branch_taken &&
                  (state == FETCH || (state == WAIT && imem_rvalid));
    resp        = (state == WAIT) && imem_rvalid && !branch_taken;
    skid_load   = resp && (!ifid_free || skid_valid);
    skid_unload = ifid_free && skid_valid;
  end

  always_comb begin
    state_nxt = state;
    if (branch_taken) begin
      if (state != FETCH) state_nxt = imem_rvalid ? FETCH : DISCARD;
    end else if (imem_req) begin
      state_nxt = WAIT;
    end else if (imem_rvalid && state != FETCH) begin
      state_nxt = FETCH;
    end
  end

  assign imem_addr = pc;
  assign if_opcode = if_instr[OPCODE_MSB -: OPCODE_W];

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (branch_taken),
    .load       (skid_load),
    .load_instr (imem_rdata),
    .load_pc    (req_pc),
    .unload     (skid_unload),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // a request still in flight across reset must have its late response swallowed
      state    <= (state != FETCH && !imem_rvalid) ? DISCARD : FETCH;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state <= state_nxt;
      if (branch_taken) begin
        pc <= branch_target & ~XLEN'(3);
      end else if (imem_req) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
      if (branch_taken) begin
        if_valid <= 1'b0;
      end else if (ifid_free) begin
        if (skid_valid) begin
          if_valid <= 1'b1;
          if_instr <= skid_instr;
          if_pc    <= skid_pc;
        end else if (resp) begin
          if_valid <= 1'b1;
          if_instr <= imem_rdata;
          if_pc    <= req_pc;
        end else begin
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: address-derived instruction memory, stream-level model, directed scenarios.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  if_opcode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_opcode     (if_opcode)
  );

  // word at address a: opcode field = (a/4)+1, low bits = a, so 0x0 -> 32'h0800_0000
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (((a >> 2) + 32'd1) << 27) | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: fixed latency per request, taken from mem_lat when the request is seen
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (imem_req) begin
        pend_addr = imem_addr;
        pend_cnt  = mem_lat;
      end
      @(posedge clk);
      #1;
      if (pend_cnt > 0) begin
        pend_cnt--;
        imem_rvalid = (pend_cnt == 0);
        imem_rdata  = (pend_cnt == 0) ? mem_word(pend_addr) : 32'h0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // stream model: which address must be requested next, which pc must appear next in IF/ID
  logic [31:0] m_req_exp  = RST_PC;
  logic [31:0] m_emit_exp = RST_PC;
  logic [31:0] m_cur_pc   = 32'h0;
  bit          m_out = 0, m_drop = 0, m_flush = 1, m_hold = 0;
  int          m_emits = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("req_in_reset", {31'd0, imem_req}, 32'd0);
        if (m_out && !imem_rvalid) m_drop = 1;
        else begin
          m_out  = 0;
          m_drop = 0;
        end
        m_req_exp  = RST_PC;
        m_emit_exp = RST_PC;
        m_flush    = 1;
        m_hold     = 0;
      end else begin
        if (m_flush) begin
          chk("flushed_valid", {31'd0, if_valid}, 32'd0);
        end else if (m_hold) begin
          chk("hold_valid", {31'd0, if_valid}, 32'd1);
          chk("hold_pc", if_pc, m_cur_pc);
          chk("hold_instr", if_instr, mem_word(m_cur_pc));
        end else if (if_valid) begin
          chk("emit_pc", if_pc, m_emit_exp);
          chk("emit_instr", if_instr, mem_word(m_emit_exp));
          chk("emit_opcode", {27'd0, if_opcode}, mem_word(m_emit_exp) >> 27);
          m_cur_pc   = m_emit_exp;
          m_emit_exp = m_emit_exp + 32'd4;
          m_emits++;
        end
        if (imem_req) begin
          chk("req_addr", imem_addr, m_req_exp);
          chk("req_while_outstanding", {31'd0, m_out && (m_drop || !imem_rvalid)}, 32'd0);
          chk("req_during_branch", {31'd0, branch_taken}, 32'd0);
        end
        if (imem_rvalid && m_out) begin
          m_out  = 0;
          m_drop = 0;
        end
        if (branch_taken) begin
          if (m_out) m_drop = 1;
          m_req_exp  = branch_target & ~32'd3;
          m_emit_exp = branch_target & ~32'd3;
          m_flush    = 1;
          m_hold     = 0;
        end else begin
          m_flush = 0;
          m_hold  = if_valid && stall;
          if (imem_req) begin
            m_out     = 1;
            m_drop    = 0;
            m_req_exp = m_req_exp + 32'd4;
          end
        end
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    repeat (n) cyc_start();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string name, output logic [31:0] addr);
    bit found = 0;
    addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1;
        addr  = imem_addr;
      end else begin
        cyc_start();
      end
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] a;
  int          emits_before;
  localparam logic [7:0] STALL_PAT = 8'b0110_0100;
  int lat_tab[4] = '{1, 2, 1, 3};

  initial begin
    // basic streaming from reset with 1-cycle memory
    mem_lat = 1;
    repeat (2) cyc_start();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("a_req0", {31'd0, imem_req}, 32'd1);
    chk("a_addr0", imem_addr, 32'h0);
    cyc_start();
    @(negedge clk);
    chk("a_addr1", imem_addr, 32'h4);
    cyc_start();
    @(negedge clk);
    chk("a_addr2", imem_addr, 32'h8);
    chk("a_valid2", {31'd0, if_valid}, 32'd1);
    chk("a_instr2", if_instr, 32'h0800_0000);
    chk("a_opcode2", {27'd0, if_opcode}, 32'd1);
    repeat (4) cyc_start();

    // one-cycle reset while a slow request is outstanding
    mem_lat = 3;
    wait_req("b_req_seen", a);
    cyc_start();
    rst_n = 1'b0;
    @(negedge clk);
    chk("b_req_in_reset", {31'd0, imem_req}, 32'd0);
    cyc_start();
    rst_n = 1'b1;
    mem_lat = 1;
    @(negedge clk);
    chk("b_discard_no_req", {31'd0, imem_req}, 32'd0);
    cyc_start();
    wait_req("b_req_after", a);
    chk("b_addr_reset_pc", a, RST_PC);

    // stall for three cycles while the word at 0x4 returns
    cyc_start();
    do_reset(4);
    @(negedge clk);
    cyc_start();
    cyc_start();
    stall = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("c_req_stalled", {31'd0, imem_req}, 32'd0);
      chk("c_pc_held", if_pc, 32'h0);
      if (c < 4) cyc_start();
    end
    cyc_start();
    stall = 1'b0;
    @(negedge clk);
    chk("c5_pc", if_pc, 32'h0);
    chk("c5_req", {31'd0, imem_req}, 32'd0);
    cyc_start();
    @(negedge clk);
    chk("c6_valid", {31'd0, if_valid}, 32'd1);
    chk("c6_pc", if_pc, 32'h4);
    chk("c6_instr", if_instr, 32'h1000_0004);
    chk("c6_addr", imem_addr, 32'h8);

    // branch while waiting on a slow response
    repeat (3) cyc_start();
    mem_lat = 3;
    wait_req("d_req_seen", a);
    cyc_start();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    @(negedge clk);
    chk("d_req_branch", {31'd0, imem_req}, 32'd0);
    cyc_start();
    branch_taken = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    chk("d_valid_flushed", {31'd0, if_valid}, 32'd0);
    chk("d_req_discard", {31'd0, imem_req}, 32'd0);
    cyc_start();
    wait_req("d_req_target", a);
    chk("d_addr_target", a, 32'h0000_0100);

    // branch coincident with a response while stalled
    repeat (3) cyc_start();
    wait_req("e_req_seen", a);
    cyc_start();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    @(negedge clk);
    chk("e_req_branch", {31'd0, imem_req}, 32'd0);
    cyc_start();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("e_valid", {31'd0, if_valid}, 32'd0);
    chk("e_req", {31'd0, imem_req}, 32'd1);
    chk("e_addr", imem_addr, 32'h0000_0200);
    cyc_start();
    stall = 1'b0;

    // pc wrap at the top of the address space
    repeat (2) cyc_start();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    cyc_start();
    branch_taken = 1'b0;
    wait_req("f_req_top", a);
    chk("f_addr_top", a, 32'hFFFF_FFFC);
    cyc_start();
    wait_req("f_req_wrap", a);
    chk("f_addr_wrap", a, 32'h0000_0000);

    // mixed stalls, latencies and redirects, checked by the stream model
    emits_before = m_emits;
    for (int i = 0; i < 48; i++) begin
      cyc_start();
      stall         = STALL_PAT[i % 8];
      mem_lat       = lat_tab[i % 4];
      branch_taken  = (i == 17 || i == 33);
      branch_target = (i == 17) ? 32'h0000_0080 : 32'h0000_03C1;
    end
    cyc_start();
    branch_taken = 1'b0;
    stall = 1'b0;
    mem_lat = 1;
    repeat (10) cyc_start();
    chk("g_progress", {31'd0, m_emits > emits_before + 10}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
